vga_rect_fill_80x60: RTL

VGA_RECT_FILL_80X60 -- requirements
Module: vga_rect_fill_80x60

---
 rtl/vga_rect_fill_80x60.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/vga_rect_fill_80x60.sv
// vga_rect_fill_80x60: rectangle fill/outline/XOR engine writing an 80x60 8-bit framebuffer
// Ports:
//   CLK_50MHz     clock, all state on rising edge
//   RST           asynchronous active-high reset
//   START         one-cycle request, sampled only in IDLE
//   X0, X1        rectangle corner columns
//   Y0, Y1        rectangle corner rows
//   COLOR         RRRGGGBB pixel value
//   MODE          00 solid, 01 outline, 10 XOR fill, 11 reserved
//   RD            framebuffer read data for the address currently on WA
//   WA, WD, WE    framebuffer write port, address {row, col}
//   BUSY, DONE    operation in progress / one-cycle completion pulse
//   ERR           one-cycle pulse with DONE when a request is rejected
module vga_rect_fill_80x60 #(
    parameter int COLS = 80,
    parameter int ROWS = 60
) (
    input  logic        CLK_50MHz,
    input  logic        RST,
    input  logic        START,
    input  logic [6:0]  X0,
    input  logic [6:0]  X1,
    input  logic [5:0]  Y0,
    input  logic [5:0]  Y1,
    input  logic [7:0]  COLOR,
    input  logic [1:0]  MODE,
    input  logic [7:0]  RD,
    output logic [12:0] WA,
    output logic [7:0]  WD,
    output logic        WE,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] FILL = 3'd1;
    localparam logic [2:0] XRD  = 3'd2;
    localparam logic [2:0] XWR  = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    logic [2:0] state;
    logic [6:0] x, xmin, xmax, nx, in_xmin, in_xmax;
    logic [5:0] y, ymin, ymax, ny, in_ymin, in_ymax;
    logic [7:0] color;
    logic [1:0] mode;
    logic       bad, last, next_on_border;

    always_comb begin
        in_xmin = X0 < X1 ? X0 : X1;
        in_xmax = X0 < X1 ? X1 : X0;
        in_ymin = Y0 < Y1 ? Y0 : Y1;
        in_ymax = Y0 < Y1 ? Y1 : Y0;
        bad = X0 >= 7'(COLS) || X1 >= 7'(COLS) || Y0 >= 6'(ROWS) || Y1 >= 6'(ROWS) || MODE == 2'b11;
        last = x == xmax && y == ymax;
        nx = x == xmax ? xmin : x + 7'd1;
        ny = x == xmax ? y + 6'd1 : y;
        next_on_border = nx == xmin || nx == xmax || ny == ymin || ny == ymax;
    end

    // x/y always hold the pixel currently presented on WA (or skipped in outline mode)
    always_ff @(posedge CLK_50MHz or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            xmin  <= '0;
            xmax  <= '0;
            ymin  <= '0;
            ymax  <= '0;
            color <= '0;
            mode  <= '0;
            WA    <= '0;
            WD    <= '0;
            WE    <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            WE   <= 1'b0;
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                IDLE: if (START) begin
                    if (bad) begin
                        state <= FIN;
                        DONE  <= 1'b1;
                        ERR   <= 1'b1;
                    end else begin
                        xmin  <= in_xmin;
                        xmax  <= in_xmax;
                        ymin  <= in_ymin;
                        ymax  <= in_ymax;
                        x     <= in_xmin;
                        y     <= in_ymin;
                        color <= COLOR;
                        mode  <= MODE;
                        BUSY  <= 1'b1;
                        WA    <= {in_ymin, in_xmin};
                        // the first pixel is a corner, so outline mode writes it too
                        if (MODE == 2'b10) begin
                            state <= XRD;
                        end else begin
                            state <= FILL;
                            WE    <= 1'b1;
                            WD    <= COLOR;
                        end
                    end
                end
                FILL: if (last) begin
                    state <= FIN;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                end else begin
                    x <= nx;
                    y <= ny;
                    if (mode == 2'b00 || next_on_border) begin
                        WE <= 1'b1;
                        WA <= {ny, nx};
                        WD <= color;
                    end
                end
                XRD: begin
                    state <= XWR;
                    WE    <= 1'b1;
                    WD    <= RD ^ color;
                end
                XWR: if (last) begin
                    state <= FIN;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                end else begin
                    state <= XRD;
                    x     <= nx;
                    y     <= ny;
                    WA    <= {ny, nx};
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
